ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX pipeline register outputs and selects operands through the forwarding muxes.
- It computes the ALU result and resolves branches and jumps, driving PCSrcE and PCTargetE back to fetch.
- It contains the EX/MEM pipeline register, whose outputs feed the memory stage.
- ALUResultM is fed back internally as the EX-to-EX forwarding source.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/alu.sv | 38 +++
 rtl/ex_stage.sv | 97 +++++++++
 tb/tb_ex_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
// ALU op encodings, forwarding-mux selects and writeback-source codes.
package pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  // Code 2'b11 is not enumerated; the forwarding muxes treat it as FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I-subset ALU: add/sub/and/or/xor/slt/sll/srl plus zero flag.
// Shift amount is the low five bits of b; add and sub wrap silently.
module alu
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  logic       lessThan;
  logic [4:0] shamt;

  assign lessThan = $signed(a) < $signed(b);
  assign shamt    = b[4:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, lessThan};
      ALU_SLL: y = a << shamt;
      ALU_SRL: y = a >> shamt;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// ALUResultM loops back as the EX-to-EX forwarding source.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [REGW-1:0] RdE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic [1:0]      ResultSrcM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [REGW-1:0] RdM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] WriteDataE;
  logic [XLEN-1:0] SrcBE;
  logic [XLEN-1:0] ALUResultE;
  logic            ZeroE;

  // Unlisted select code 2'b11 falls through to the register-file operand.
  always_comb begin
    SrcAE = RD1E;
    case (ForwardAE)
      FWD_WB:  SrcAE = ResultW;
      FWD_MEM: SrcAE = ALUResultM;
      default: SrcAE = RD1E;
    endcase
  end

  always_comb begin
    WriteDataE = RD2E;
    case (ForwardBE)
      FWD_WB:  WriteDataE = ResultW;
      FWD_MEM: WriteDataE = ALUResultM;
      default: WriteDataE = RD2E;
    endcase
  end

  assign SrcBE = ALUSrcE ? ImmExtE : WriteDataE;

  alu #(.XLEN(XLEN)) uAlu (
    .a    (SrcAE),
    .b    (SrcBE),
    .op   (alu_op_t'(ALUControlE)),
    .y    (ALUResultE),
    .zero (ZeroE)
  );

  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = JumpE | (BranchE & ZeroE);

  // No stall/flush port: squashing is done upstream by zeroing ID/EX.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= RES_ALU;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU sweep, forwarding, branch/jump, store and bubble.
// Inputs change 1 ns after a rising edge; outputs are checked before the next edge or 1 ns after it.
module tb_ex_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [2:0]  sweepOp  [8];
  logic [31:0] sweepExp [8];

  always #5 CLK = ~CLK;

  ex_stage dut (
    .CLK(CLK), .RST(RST),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .RdE(RdE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
    ALUControlE = 0; ALUSrcE = 0; RD1E = 0; RD2E = 0; PCE = 0; RdE = 0;
    ImmExtE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  initial begin
    sweepOp[0] = 3'b000; sweepExp[0] = 32'h0000_0001;
    sweepOp[1] = 3'b001; sweepExp[1] = 32'hFFFF_FFFB;
    sweepOp[2] = 3'b010; sweepExp[2] = 32'h0000_0002;
    sweepOp[3] = 3'b011; sweepExp[3] = 32'hFFFF_FFFF;
    sweepOp[4] = 3'b100; sweepExp[4] = 32'hFFFF_FFFD;
    sweepOp[5] = 3'b101; sweepExp[5] = 32'h0000_0001;
    sweepOp[6] = 3'b110; sweepExp[6] = 32'hFFFF_FFF0;
    sweepOp[7] = 3'b111; sweepExp[7] = 32'h1FFF_FFFF;

    // Reset held for two edges with busy inputs
    clear_inputs();
    RST = 1;
    RegWriteE = 1; ResultSrcE = 2'b10; MemWriteE = 1; RD1E = 32'd5; RD2E = 32'd6;
    RdE = 5'd7; PCPlus4E = 32'h44;
    step();
    step();
    chk("rst_regwrite",  {31'd0, RegWriteM}, 32'd0);
    chk("rst_resultsrc", {30'd0, ResultSrcM}, 32'd0);
    chk("rst_memwrite",  {31'd0, MemWriteM}, 32'd0);
    chk("rst_aluresult", ALUResultM, 32'd0);
    chk("rst_writedata", WriteDataM, 32'd0);
    chk("rst_rd",        {27'd0, RdM}, 32'd0);
    chk("rst_pcplus4",   PCPlus4M, 32'd0);
    RST = 0;
    step();
    chk("post_rst_aluresult", ALUResultM, 32'd11);
    chk("post_rst_writedata", WriteDataM, 32'd6);
    chk("post_rst_rd",        {27'd0, RdM}, 32'd7);
    chk("post_rst_pcplus4",   PCPlus4M, 32'h44);
    chk("post_rst_ctrl", {27'd0, RegWriteM, ResultSrcM, MemWriteM, 1'b0}, {27'd0, 1'b1, 2'b10, 1'b1, 1'b0});

    // ALU sweep with register operands
    clear_inputs();
    RD1E = 32'hFFFF_FFFE; RD2E = 32'h0000_0003;
    for (int i = 0; i < 8; i++) begin
      ALUControlE = sweepOp[i];
      step();
      chk($sformatf("alu_op%0d", i), ALUResultM, sweepExp[i]);
    end

    // Forwarding: immediate add, then MEM-forward A and WB-forward B
    clear_inputs();
    RD1E = 32'd5; ImmExtE = 32'd7; ALUSrcE = 1; ALUControlE = 3'b000;
    step();
    chk("fwd_first", ALUResultM, 32'd12);
    ALUSrcE = 0; ALUControlE = 3'b001; ForwardAE = 2'b10; ForwardBE = 2'b01;
    ResultW = 32'd3; RD1E = 32'd100; RD2E = 32'd200;
    step();
    chk("fwd_alu", ALUResultM, 32'd9);
    chk("fwd_wdata", WriteDataM, 32'd3);

    // Select code 11 falls back to register operands
    ForwardAE = 2'b11; ForwardBE = 2'b11; RD1E = 32'd20; RD2E = 32'd4; ResultW = 32'd99;
    step();
    chk("fwd11_alu", ALUResultM, 32'd16);
    chk("fwd11_wdata", WriteDataM, 32'd4);

    // Branch resolution, combinational
    clear_inputs();
    BranchE = 1; RD1E = 32'h40; RD2E = 32'h40; ALUControlE = 3'b001;
    PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    #1;
    chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
    chk("beq_target", PCTargetE, 32'h0000_00F0);
    RD2E = 32'h41;
    #1;
    chk("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    PCE = 32'hFFFF_FFF0; ImmExtE = 32'h20;
    #1;
    chk("target_wrap", PCTargetE, 32'h0000_0010);
    step();

    // Jump: taken regardless of zero flag
    clear_inputs();
    JumpE = 1; ResultSrcE = 2'b10; RegWriteE = 1; PCPlus4E = 32'h204;
    RD1E = 32'd1; RD2E = 32'd0; ALUControlE = 3'b001; RdE = 5'd1;
    #1;
    chk("jal_pcsrc", {31'd0, PCSrcE}, 32'd1);
    step();
    chk("jal_pcplus4", PCPlus4M, 32'h204);
    chk("jal_resultsrc", {30'd0, ResultSrcM}, 32'd2);
    chk("jal_regwrite", {31'd0, RegWriteM}, 32'd1);

    // Store data forwarded from the previous ALU result
    clear_inputs();
    RD1E = 32'h50; RD2E = 32'd5; ALUControlE = 3'b000;
    step();
    chk("st_prior", ALUResultM, 32'h55);
    MemWriteE = 1; ForwardBE = 2'b10; RD2E = 32'hDEAD; ALUSrcE = 1;
    ImmExtE = 32'd8; RD1E = 32'h1000;
    step();
    chk("st_wdata", WriteDataM, 32'h55);
    chk("st_addr", ALUResultM, 32'h1008);
    chk("st_memwrite", {31'd0, MemWriteM}, 32'd1);

    // All-zero bubble
    clear_inputs();
    #1;
    chk("bubble_pcsrc", {31'd0, PCSrcE}, 32'd0);
    step();
    chk("bubble_regwrite", {31'd0, RegWriteM}, 32'd0);
    chk("bubble_memwrite", {31'd0, MemWriteM}, 32'd0);
    chk("bubble_alu", ALUResultM, 32'd0);

    // Mid-stream reset squashes only the instruction captured on that edge
    RD1E = 32'd9; RD2E = 32'd1; RdE = 5'd3; RegWriteE = 1; RST = 1;
    step();
    chk("mid_rst_alu", ALUResultM, 32'd0);
    chk("mid_rst_regwrite", {31'd0, RegWriteM}, 32'd0);
    RST = 0;
    step();
    chk("mid_rst_after_alu", ALUResultM, 32'd10);
    chk("mid_rst_after_rd", {27'd0, RdM}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
